codificador_teclado_n: RTL
==========================

# codificador_teclado_n

Parametrised keypad input front-end for the microwave controller: synchronises an N-key keypad, priority-encodes it, debounces the code with a counter FSM, and emits a one-cycle active-low load strobe per accepted press. In count mode the same block supplies a divided seconds tick on `pgt_1Hz`. An optional auto-repeat engine produces repeated load strobes while a key is held. It sits between the keypad pins and the time-entry register/counter chain.

## Interface
- `N_KEYS`, 10: number of keypad lines; key index i encodes as value i.
- `CODE_W`, 4: width of `out_codificado`; must satisfy 2^CODE_W >= N_KEYS.
- `DEBOUNCE_CYC`, 5: consecutive stable cycles required to accept a press or a release (>= 1).
- `TICK_DIV`, 100: clock cycles per `pgt_1Hz` tick in count mode (>= 2).
- `REPEAT_DLY`, 50: hold cycles after acceptance before the first repeat (used only with `AUTOREPEAT_EN`).
- `REPEAT_RATE`, 10: cycles between repeats (used only with `AUTOREPEAT_EN`).

Ports:
- `clk100Hz` input 1: single system clock, rising edge.
- `clrn` input 1: asynchronous, active-low reset.
- `teclado` input N_KEYS: raw keypad lines, active high, asynchronous to the clock.
- `enablen` input 1: 0 = input mode (keypad active); 1 = count mode (keypad ignored, tick active).
- `out_codificado` output CODE_W: code of the last accepted key, registered.
- `loadn` output 1: active-low one-cycle strobe per accepted press or repeat.
- `key_held` output 1: high while an accepted key remains held.
- `pgt_1Hz` output 1: input mode = copy of the accept strobe (active high); count mode = divider tick.

## Operation
- All `teclado` lines pass through a 2-flop synchroniser. The priority encoder picks the highest asserted index. `any` = OR of the synchronised lines.
- FSM states and transitions:
  - IDLE -> DEB_PRESS on `any`. Capture the code and set cnt = 1.
  - DEB_PRESS: if `any` is set and the code equals the captured code, cnt++. At cnt == DEBOUNCE_CYC: go to HELD, load `out_codificado`, pulse `loadn` low. If `any` drops or the code changes, return to IDLE.
  - HELD: `key_held` = 1. Code changes are ignored (no rollover). When `any` drops, go to DEB_REL with cnt = 1.
  - DEB_REL: cnt++ while `any` = 0. At cnt == DEBOUNCE_CYC, go to IDLE. If `any` reasserts, return to HELD.
- `enablen` = 1 forces the FSM to IDLE on the next edge, forces `loadn` = 1 and `key_held` = 0, and holds `out_codificado`.
- Divider: the counter is held at 0 while `enablen` = 0. While `enablen` = 1 it counts 0..TICK_DIV-1 and wraps. `pgt_1Hz` is high for one cycle when the count equals TICK_DIV-1.
- Counter widths are $clog2 of their maximum value. No counter saturates past its limit.

## Timing
- Reset values: FSM IDLE, all counters 0, `out_codificado` = 0, `loadn` = 1, `key_held` = 0, `pgt_1Hz` = 0.
- Press latency: count the first edge that samples a stable key as edge 1. `loadn` goes low after edge DEBOUNCE_CYC+2 and returns high after the next edge. `out_codificado` updates on the same edge and stays stable afterwards.
- In input mode, `pgt_1Hz` is high in exactly the same cycle that `loadn` is low.
- Release: `key_held` falls after edge DEBOUNCE_CYC+2 counted from the first low sample. A new press is not accepted before the FSM returns to IDLE.
- Count mode: the first tick comes TICK_DIV cycles after the edge that samples `enablen` = 1. Period is TICK_DIV cycles thereafter.
- Simultaneous `enablen` rise and accept edge: `enablen` wins, so no strobe is issued.
- `clrn` asserted mid-operation: all outputs go to their reset values immediately, with no strobe.

## Configuration
- `CODIFICADOR_AUTOREPEAT_EN` defined:
  - HELD additionally runs a repeat counter.
  - After REPEAT_DLY cycles in HELD, a `loadn` strobe is issued, with the same code and the same `pgt_1Hz` copy.
  - Further strobes follow every REPEAT_RATE cycles until leaving HELD.
  - A DEB_REL bounce back to HELD restarts the REPEAT_DLY count.
- Not defined: the repeat logic is absent, and exactly one strobe is issued per debounced press.

## Test plan
- Reset: hold `clrn` = 0 with keys pressed -> `out_codificado` = 0, `loadn` = 1, `key_held` = 0, `pgt_1Hz` = 0. Release reset -> no spurious strobe.
- Clean press of key 7 (defaults) -> exactly one `loadn` low after edge 7 and `out_codificado` = 7. `key_held` rises and then falls 7 edges after release.
- Bounce: key 3 toggled every 2 cycles for 20 cycles, then stable -> a single strobe after the stable period and `out_codificado` = 3.
- Keys 2 and 9 held together -> `out_codificado` = 9. Then drop key 9 while still holding key 2 -> no new strobe.
- `enablen` = 1 for 350 cycles -> `pgt_1Hz` pulses at cycles 100, 200 and 300, and key presses produce no strobe. `enablen` back to 0 -> divider silent.
- With `CODIFICADOR_AUTOREPEAT_EN`: hold key 5 for 100 cycles after acceptance -> strobes at acceptance, +50, +60, +70, +80, +90 and +100.

Source files
------------

// File: rtl/codificador_teclado_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | codificador_teclado_n                                                      |
// | Keypad front-end: sync, priority encode, debounce, load strobe, 1 Hz tick. |
// | Option macro: CODIFICADOR_AUTOREPEAT_EN (auto-repeat while key held).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module codificador_teclado_n #(
    parameter int N_KEYS       = 10,
    parameter int CODE_W       = 4,
    parameter int DEBOUNCE_CYC = 5,
    parameter int TICK_DIV     = 100,
    parameter int REPEAT_DLY   = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic              clk100Hz,
    input  logic              clrn,
    input  logic [N_KEYS-1:0] teclado,
    input  logic              enablen,
    output logic [CODE_W-1:0] out_codificado,
    output logic              loadn,
    output logic              key_held,
    output logic              pgt_1Hz
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_DEB_PRESS = 2'd1;
    localparam logic [1:0] c_HELD      = 2'd2;
    localparam logic [1:0] c_DEB_REL   = 2'd3;

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

    localparam int c_DIV_W = $clog2(TICK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE = c_DIV_W'(1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);

    generate
        if ((1 << CODE_W) < N_KEYS || DEBOUNCE_CYC < 1 || TICK_DIV < 2 ||
            REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_params
            $error("codificador_teclado_n: illegal parameter set");
        end
    endgenerate

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [CODE_W-1:0] r_cap;
    logic [CODE_W-1:0] r_out;
    logic [CODE_W-1:0] w_code;
    logic              w_any;
    logic              w_accept;
    logic              w_cap_load;
    logic              w_rep_strobe;
    logic              r_loadn;
    logic [c_DIV_W-1:0] r_div;
    logic              r_tick;

    always_ff @(posedge clk100Hz or negedge clrn) begin
        if (!clrn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= teclado;
            r_sync2 <= r_sync1;
        end
    end

    // Later (higher) indices overwrite earlier ones: highest key wins.
    always_comb begin
        w_code = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (r_sync2[i]) begin
                w_code = CODE_W'(i);
            end
        end
    end

    assign w_any = |r_sync2;

    always_ff @(posedge clk100Hz or negedge clrn) begin
        if (!clrn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        w_accept   = 1'b0;
        w_cap_load = 1'b0;
        if (enablen) begin
            w_next    = c_IDLE;
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_any) begin
                        w_cap_load = 1'b1;
                        if (DEBOUNCE_CYC == 1) begin
                            w_next   = c_HELD;
                            w_accept = 1'b1;
                        end else begin
                            w_next    = c_DEB_PRESS;
                            w_cnt_nxt = c_CNT_ONE;
                        end
                    end
                end
                c_DEB_PRESS: begin
                    if (w_any && (w_code == r_cap)) begin
                        if (r_cnt == c_DEB_LAST) begin
                            w_next    = c_HELD;
                            w_accept  = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end else begin
                        w_next    = c_IDLE;
                        w_cnt_nxt = '0;
                    end
                end
                c_HELD: begin
                    if (!w_any) begin
                        if (DEBOUNCE_CYC == 1) begin
                            w_next    = c_IDLE;
                            w_cnt_nxt = '0;
                        end else begin
                            w_next    = c_DEB_REL;
                            w_cnt_nxt = c_CNT_ONE;
                        end
                    end
                end
                c_DEB_REL: begin
                    if (w_any) begin
                        w_next    = c_HELD;
                        w_cnt_nxt = '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        w_next    = c_IDLE;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_next    = c_IDLE;
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        key_held       = ((r_state == c_HELD) || (r_state == c_DEB_REL)) && !enablen;
        loadn          = r_loadn;
        out_codificado = r_out;
        pgt_1Hz        = enablen ? r_tick : ~r_loadn;
    end

    always_ff @(posedge clk100Hz or negedge clrn) begin
        if (!clrn) begin
            r_cnt   <= '0;
            r_cap   <= '0;
            r_out   <= '0;
            r_loadn <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_loadn <= ~(w_accept | w_rep_strobe);
            if (w_cap_load) begin
                r_cap <= w_code;
            end
            if (w_accept) begin
                r_out <= w_code;
            end
        end
    end

`ifdef CODIFICADOR_AUTOREPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int c_REP_W   = (c_REP_MAX > 1) ? $clog2(c_REP_MAX) : 1;
    localparam logic [c_REP_W-1:0] c_REP_ONE      = c_REP_W'(1);
    localparam logic [c_REP_W-1:0] c_REP_DLY_LAST = c_REP_W'(REPEAT_DLY - 1);
    localparam logic [c_REP_W-1:0] c_REP_RAT_LAST = c_REP_W'(REPEAT_RATE - 1);

    logic [c_REP_W-1:0] r_rep;
    logic               r_rep_ph;
    logic [c_REP_W-1:0] w_rep_lim;

    // Phase 0 waits out the initial delay; phase 1 paces subsequent repeats.
    assign w_rep_lim    = r_rep_ph ? c_REP_RAT_LAST : c_REP_DLY_LAST;
    assign w_rep_strobe = (r_state == c_HELD) && w_any && !enablen && (r_rep == w_rep_lim);

    always_ff @(posedge clk100Hz or negedge clrn) begin
        if (!clrn) begin
            r_rep    <= '0;
            r_rep_ph <= 1'b0;
        end else if ((r_state != c_HELD) || enablen) begin
            r_rep    <= '0;
            r_rep_ph <= 1'b0;
        end else if (r_rep == w_rep_lim) begin
            r_rep    <= '0;
            r_rep_ph <= 1'b1;
        end else begin
            r_rep <= r_rep + c_REP_ONE;
        end
    end
`else
    assign w_rep_strobe = 1'b0;
`endif

    always_ff @(posedge clk100Hz or negedge clrn) begin
        if (!clrn) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (enablen) begin
            r_tick <= (r_div == c_DIV_LAST);
            r_div  <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_ONE;
        end else begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end
    end

endmodule
`default_nettype wire
